gx4000_cart_arbiter: RTL and testbench
======================================

Name: gx4000_cart_arbiter

Overview:
- Sequences every access to the shared cartridge ROM memory port (SDRAM/BRAM holding CPR/BIN images) in GX4000/Plus mode.
- Arbitrates between three requesters: ioctl download writer, Z80 cartridge reads (bank-mapped address already formed), ASIC DMA sound fetches.
- Fixed priority with a DMA anti-starvation guard; one outstanding memory transaction at a time.

Parameters:
ADDR_W, 23, width of ROM address on all ports
DMA_MAX_WAIT, 16, cycles DMA may wait (req high, not granted) before being promoted above CPU
TIMEOUT, 255, cycles in ISSUE before abort (only with optional feature)

Ports:
clk_sys  in  1  system clock
reset_n  in  1  asynchronous active-low reset
dl_req  in  1  download write request (level, held until dl_ack)
dl_addr  in  ADDR_W  download address
dl_data  in  8  download byte
dl_ack  out  1  one-cycle completion pulse
cpu_req  in  1  CPU cart read request (level)
cpu_addr  in  ADDR_W  CPU ROM address
cpu_ack  out  1  one-cycle completion pulse
cpu_q  out  8  read data, valid from cpu_ack onward, held until next CPU completion
dma_req  in  1  DMA read request (level)
dma_addr  in  ADDR_W  DMA ROM address
dma_ack  out  1  one-cycle completion pulse
dma_q  out  8  read data, same rules as cpu_q
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  1 = write (download), 0 = read
mem_addr  out  ADDR_W  latched address
mem_din  out  8  write data
mem_ack  in  1  one-cycle memory completion
mem_dout  in  8  read data, valid with mem_ack
owner  out  2  current grant: 0 none, 1 DL, 2 CPU, 3 DMA
err_timeout  out  1  sticky timeout flag (0 when feature off)

Behaviour:
- Reset (async, reset_n=0): state IDLE; all outputs 0 (mem_req, mem_we, mem_addr, mem_din, acks, cpu_q, dma_q, owner, err_timeout); dma_wait=0. Takes effect immediately, including mid-ISSUE; mem_req drops at once and the memory side tolerates the abandoned request.
- FSM IDLE -> ISSUE -> DONE -> IDLE.
- IDLE: at an edge where any req=1, pick winner, latch mem_addr/mem_din/mem_we from winner, set owner, mem_req<=1, go ISSUE. No req: stay.
- Priority: DL > CPU > DMA; if dma_wait >= DMA_MAX_WAIT then DL > DMA > CPU.
- dma_wait: +1 each cycle dma_req=1 and owner!=3, saturates at DMA_MAX_WAIT; cleared on DMA grant or dma_req=0.
- ISSUE: mem_req held, inputs from requesters ignored. Edge with mem_ack=1: mem_req<=0; if read, owner's q<=mem_dout; owner's ack<=1; go DONE.
- DONE: exactly one cycle; ack high; owner<=0 on exit; go IDLE. Requests not sampled in DONE. Requester must deassert req at the edge where its ack is high (else it is served again).
- Minimum transaction: req sampled E0, mem_req high after E0, mem_ack earliest at E1, ack high E1–E2, next grant decision at E3 edge.
- mem_ack outside ISSUE ignored. Changes to req addr/data after grant ignored.
- Only one ack asserted in any cycle; mem_req never high outside ISSUE.

Optional Feature:
Macro GX4000_CART_ARB_TIMEOUT_EN.
- Defined: counter starts 0 on ISSUE entry, +1 per ISSUE cycle; when it reaches TIMEOUT with no mem_ack: mem_req<=0, owner's ack pulsed via DONE, read q<=8'hFF, err_timeout<=1 (sticky until reset). mem_ack on the same edge as expiry wins (normal completion).
- Undefined: ISSUE waits indefinitely; err_timeout constant 0; no counter logic.

Test Plan:
- Single CPU read: cpu_req=1, cpu_addr=23'h004123, mem_ack 2 cycles after mem_req with mem_dout=8'h5A -> mem_addr=23'h004123, mem_we=0, cpu_ack one cycle, cpu_q=8'h5A, owner 2 then 0.
- Simultaneous dl/cpu/dma all asserted at one edge -> service order DL (mem_we=1, mem_din=dl_data), CPU, DMA; never two acks together.
- Starvation, DMA_MAX_WAIT=4: CPU re-requests immediately after every ack, DMA held high, mem_ack immediate -> DMA granted once dma_wait reaches 4, ahead of pending CPU; dma_wait back to 0.
- reset_n pulsed low during ISSUE -> mem_req, owner, acks 0 asynchronously; after release with no req, stays idle; a late mem_ack is ignored.
- Spurious mem_ack=1 in IDLE with mem_dout=8'h77 -> no ack, cpu_q/dma_q unchanged.
- With GX4000_CART_ARB_TIMEOUT_EN, TIMEOUT=8, DMA read, no mem_ack -> after 8 ISSUE cycles dma_ack pulses, dma_q=8'hFF, err_timeout=1 and stays 1 through following good transactions.

Source files
------------

// File: rtl/gx4000_cart_arbiter.sv
// gx4000_cart_arbiter: shared cartridge ROM port sequencer for DL/CPU/DMA (optional timeout: GX4000_CART_ARB_TIMEOUT_EN)
module gx4000_cart_arbiter #(
    parameter int ADDR_W       = 23,
    parameter int DMA_MAX_WAIT = 16
`ifdef GX4000_CART_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT      = 255
`endif
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              dl_req,
    input  logic [ADDR_W-1:0] dl_addr,
    input  logic [7:0]        dl_data,
    output logic              dl_ack,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_ack,
    output logic [7:0]        cpu_q,
    input  logic              dma_req,
    input  logic [ADDR_W-1:0] dma_addr,
    output logic              dma_ack,
    output logic [7:0]        dma_q,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din,
    input  logic              mem_ack,
    input  logic [7:0]        mem_dout,
    output logic [1:0]        owner,
    output logic              err_timeout
);
    localparam int WW = $clog2(DMA_MAX_WAIT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    state_t            state_q, state_d;
    logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_din_q, mem_din_d, cpu_q_q, cpu_q_d, dma_q_q, dma_q_d;
    logic              dl_ack_q, dl_ack_d, cpu_ack_q, cpu_ack_d, dma_ack_q, dma_ack_d;
    logic [1:0]        owner_q, owner_d, win;
    logic [WW-1:0]     dma_wait_q, dma_wait_d;
    logic              dma_pri, finish;
    logic [7:0]        rd_data;

`ifdef GX4000_CART_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          err_q, err_d, expire;
`endif

    // next-state, grant selection and completion handling
    always_comb begin
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        mem_we_d   = mem_we_q;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        cpu_q_d    = cpu_q_q;
        dma_q_d    = dma_q_q;
        dl_ack_d   = 1'b0;
        cpu_ack_d  = 1'b0;
        dma_ack_d  = 1'b0;
        owner_d    = owner_q;
        dma_pri    = dma_wait_q >= WW'(DMA_MAX_WAIT);
        win        = dl_req ? 2'd1 : (dma_req && (dma_pri || !cpu_req)) ? 2'd3 : 2'd2;
        finish     = mem_ack;
        rd_data    = mem_dout;
        dma_wait_d = !dma_req ? '0 :
                     (owner_q != 2'd3 && !dma_pri) ? dma_wait_q + 1'b1 : dma_wait_q;
`ifdef GX4000_CART_ARB_TIMEOUT_EN
        tmo_cnt_d  = tmo_cnt_q;
        err_d      = err_q;
        expire     = !mem_ack && tmo_cnt_q == TW'(TIMEOUT - 1);
        finish     = mem_ack || expire;
        rd_data    = expire ? 8'hFF : mem_dout;
`endif
        case (state_q)
            IDLE: if (dl_req || cpu_req || dma_req) begin
                state_d    = ISSUE;
                owner_d    = win;
                mem_req_d  = 1'b1;
                mem_we_d   = win == 2'd1;
                mem_addr_d = win == 2'd1 ? dl_addr : win == 2'd2 ? cpu_addr : dma_addr;
                mem_din_d  = win == 2'd1 ? dl_data : 8'h00;
                dma_wait_d = win == 2'd3 ? '0 : dma_wait_d;
`ifdef GX4000_CART_ARB_TIMEOUT_EN
                tmo_cnt_d  = '0;
`endif
            end
            ISSUE: begin
`ifdef GX4000_CART_ARB_TIMEOUT_EN
                tmo_cnt_d = tmo_cnt_q + 1'b1;
                err_d     = err_q || expire;
`endif
                if (finish) begin
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                    cpu_q_d   = (!mem_we_q && owner_q == 2'd2) ? rd_data : cpu_q_q;
                    dma_q_d   = (!mem_we_q && owner_q == 2'd3) ? rd_data : dma_q_q;
                    dl_ack_d  = owner_q == 2'd1;
                    cpu_ack_d = owner_q == 2'd2;
                    dma_ack_d = owner_q == 2'd3;
                end
            end
            default: begin
                state_d = IDLE;
                owner_d = 2'd0;
            end
        endcase
    end

    // state and registered outputs, cleared asynchronously
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= 8'h00;
            cpu_q_q    <= 8'h00;
            dma_q_q    <= 8'h00;
            dl_ack_q   <= 1'b0;
            cpu_ack_q  <= 1'b0;
            dma_ack_q  <= 1'b0;
            owner_q    <= 2'd0;
            dma_wait_q <= '0;
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            cpu_q_q    <= cpu_q_d;
            dma_q_q    <= dma_q_d;
            dl_ack_q   <= dl_ack_d;
            cpu_ack_q  <= cpu_ack_d;
            dma_ack_q  <= dma_ack_d;
            owner_q    <= owner_d;
            dma_wait_q <= dma_wait_d;
        end
    end

`ifdef GX4000_CART_ARB_TIMEOUT_EN
    // ISSUE-cycle counter and sticky timeout flag
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            err_q     <= err_d;
        end
    end

    assign err_timeout = err_q;
`else
    assign err_timeout = 1'b0;
`endif

    assign mem_req  = mem_req_q;
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;
    assign cpu_q    = cpu_q_q;
    assign dma_q    = dma_q_q;
    assign dl_ack   = dl_ack_q;
    assign cpu_ack  = cpu_ack_q;
    assign dma_ack  = dma_ack_q;
    assign owner    = owner_q;
endmodule

// File: tb/tb_gx4000_cart_arbiter.sv
// tb_gx4000_cart_arbiter: scoreboard bench for the cartridge ROM arbiter
module tb_gx4000_cart_arbiter;
    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        dl_req, cpu_req, dma_req, mem_ack;
    logic [22:0] dl_addr, cpu_addr, dma_addr;
    logic [7:0]  dl_data, mem_dout;
    logic        dl_ack, cpu_ack, dma_ack, mem_req, mem_we, err_timeout;
    logic [7:0]  cpu_q, dma_q, mem_din;
    logic [22:0] mem_addr;
    logic [1:0]  owner;

    typedef struct {
        logic [1:0]  own;
        logic        we;
        logic [22:0] addr;
        logic [7:0]  din;
        logic [7:0]  rd;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   resp_lat = 0;
    int   lat_cnt = 0;
    int   cpu_rep = 0;
    bit   resp_en = 1'b1;

    gx4000_cart_arbiter #(
        .ADDR_W(23),
        .DMA_MAX_WAIT(4)
`ifdef GX4000_CART_ARB_TIMEOUT_EN
        ,
        .TIMEOUT(8)
`endif
    ) dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .dl_req(dl_req), .dl_addr(dl_addr), .dl_data(dl_data), .dl_ack(dl_ack),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_ack(cpu_ack), .cpu_q(cpu_q),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_ack(dma_ack), .dma_q(dma_q),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_ack(mem_ack), .mem_dout(mem_dout), .owner(owner), .err_timeout(err_timeout)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] o, input logic w, input logic [22:0] a,
                        input logic [7:0] d, input logic [7:0] r);
        exp_t e;
        e.own = o; e.we = w; e.addr = a; e.din = d; e.rd = r;
        exp_q.push_back(e);
    endtask

    function automatic logic [7:0] mem_val(input logic [22:0] a);
        return a == 23'h004123 ? 8'h5A : a[7:0] ^ a[15:8];
    endfunction

    task automatic tick();
        @(posedge clk_sys);
        #1;
        if (dl_ack) dl_req = 1'b0;
        if (cpu_ack) begin
            if (cpu_rep > 0) cpu_rep--;
            else cpu_req = 1'b0;
        end
        if (dma_ack) dma_req = 1'b0;
        if (resp_en) begin
            mem_ack = 1'b0;
            if (mem_req) begin
                if (lat_cnt >= resp_lat) begin
                    mem_ack  = 1'b1;
                    mem_dout = mem_val(mem_addr);
                    lat_cnt  = 0;
                end else lat_cnt++;
            end else lat_cnt = 0;
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        repeat (3) tick();
    endtask

    // monitor: checks each grant and each ack against the scoreboard head
    initial begin
        logic       pm = 1'b0;
        logic [2:0] acks, packs = 3'b0;
        exp_t       e;
        forever begin
            @(negedge clk_sys);
            acks = {dl_ack, cpu_ack, dma_ack};
            if (mem_req && !pm) begin
                if (exp_q.size() == 0) chk("unexpected_grant", {30'b0, owner}, 0);
                else begin
                    e = exp_q[0];
                    chk("grant_owner", {30'b0, owner}, {30'b0, e.own});
                    chk("grant_we", {31'b0, mem_we}, {31'b0, e.we});
                    chk("grant_addr", {9'b0, mem_addr}, {9'b0, e.addr});
                    if (e.we) chk("grant_din", {24'b0, mem_din}, {24'b0, e.din});
                end
            end
            if (acks != 3'b0) begin
                chk("ack_onehot", $countones(acks), 1);
                chk("ack_single_cycle", {29'b0, acks & packs}, 0);
                if (exp_q.size() == 0) chk("unexpected_ack", {29'b0, acks}, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("ack_which", {29'b0, acks}, {29'b0, 3'b001 << (3 - e.own)});
                    if (e.own == 2'd2) chk("cpu_q", {24'b0, cpu_q}, {24'b0, e.rd});
                    if (e.own == 2'd3) chk("dma_q", {24'b0, dma_q}, {24'b0, e.rd});
                end
            end
            pm    = mem_req;
            packs = acks;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int n;
        reset_n = 1'b0;
        {dl_req, cpu_req, dma_req, mem_ack} = 4'b0;
        dl_addr = '0; cpu_addr = '0; dma_addr = '0; dl_data = '0; mem_dout = '0;
        #3;
        chk("rst_outputs", {mem_req, mem_we, dl_ack, cpu_ack, dma_ack, owner, err_timeout,
                            cpu_q, dma_q, mem_din}, 0);
        chk("rst_addr", {9'b0, mem_addr}, 0);
        tick();
        reset_n = 1'b1;
        repeat (2) tick();

        // single CPU read, memory answers two cycles after mem_req
        resp_lat = 1;
        cpu_addr = 23'h004123;
        cpu_req  = 1'b1;
        push(2, 0, 23'h004123, 0, 8'h5A);
        drain(20);
        chk("t1_owner_idle", {30'b0, owner}, 0);
        chk("t1_cpu_q_held", {24'b0, cpu_q}, 8'h5A);

        // all three at once: DL, then CPU, then DMA
        resp_lat = 0;
        dl_addr = 23'h000100; dl_data = 8'hC3;
        cpu_addr = 23'h002010; dma_addr = 23'h003322;
        {dl_req, cpu_req, dma_req} = 3'b111;
        push(1, 1, 23'h000100, 8'hC3, 0);
        push(2, 0, 23'h002010, 0, 8'h30);
        push(3, 0, 23'h003322, 0, 8'h11);
        drain(40);

        // DMA starvation guard: CPU keeps requesting, DMA promoted after 4 waits
        cpu_rep = 2;
        {cpu_req, dma_req} = 2'b11;
        push(2, 0, 23'h002010, 0, 8'h30);
        push(2, 0, 23'h002010, 0, 8'h30);
        push(3, 0, 23'h003322, 0, 8'h11);
        push(2, 0, 23'h002010, 0, 8'h30);
        drain(60);
        chk("dma_wait_clr", {29'b0, dut.dma_wait_q}, 0);

        // spurious mem_ack while idle
        resp_en  = 1'b0;
        mem_ack  = 1'b1;
        mem_dout = 8'h77;
        repeat (2) tick();
        mem_ack = 1'b0;
        tick();
        chk("spur_acks", {29'b0, dl_ack, cpu_ack, dma_ack}, 0);
        chk("spur_cpu_q", {24'b0, cpu_q}, 8'h30);
        chk("spur_dma_q", {24'b0, dma_q}, 8'h11);
        chk("spur_mem_req", {31'b0, mem_req}, 0);

        // asynchronous reset in the middle of ISSUE
        cpu_addr = 23'h005555;
        cpu_req  = 1'b1;
        tick();
        chk("rst_pre_req", {31'b0, mem_req}, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_mid_req", {31'b0, mem_req}, 0);
        chk("rst_mid_owner", {30'b0, owner}, 0);
        chk("rst_mid_outs", {dl_ack, cpu_ack, dma_ack, cpu_q, dma_q}, 0);
        cpu_req = 1'b0;
        tick();
        reset_n = 1'b1;
        repeat (3) tick();
        chk("rst_post_idle", {29'b0, mem_req, owner}, 0);
        mem_ack  = 1'b1;
        mem_dout = 8'h99;
        tick();
        mem_ack = 1'b0;
        repeat (2) tick();
        chk("late_ack_ignored", {dl_ack, cpu_ack, dma_ack, mem_req, owner, cpu_q}, 0);
        lat_cnt = 0;
        resp_en = 1'b1;

`ifdef GX4000_CART_ARB_TIMEOUT_EN
        // DMA read never answered: times out after 8 ISSUE cycles
        resp_en  = 1'b0;
        dma_addr = 23'h003322;
        dma_req  = 1'b1;
        push(3, 0, 23'h003322, 0, 8'hFF);
        tick();
        n = 0;
        while (!dma_ack && n < 30) begin
            tick();
            n++;
        end
        chk("tmo_cycles", n, 8);
        chk("tmo_err", {31'b0, err_timeout}, 1);
        drain(10);
        lat_cnt  = 0;
        resp_en  = 1'b1;
        cpu_addr = 23'h004123;
        cpu_req  = 1'b1;
        push(2, 0, 23'h004123, 0, 8'h5A);
        drain(20);
        chk("tmo_err_sticky", {31'b0, err_timeout}, 1);
`else
        n = 0;
        chk("err_timeout_off", {31'b0, err_timeout}, n);
`endif

        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
